// File: rtl/fifo_sync_flags_if.sv
// Bus between a producer/consumer pair and fifo_sync_flags.
// Strobe semantics: winc/rinc are requests, and the FIFO accepts them only when wfull/rempty allow.
interface fifo_sync_flags_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rinc;
  logic                  clr_err;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  wfull;
  logic                  rempty;
  logic                  walmost_full;
  logic                  ralmost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output winc, wdata, rinc, clr_err,
    input  rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc, clr_err,
    output rdata, wfull, rempty, walmost_full, ralmost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with an occupancy count, programmable almost flags and sticky error flags.
// It also has an optional first-word-fall-through read path.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst,
  fifo_sync_flags_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full;
  logic                  empty;
  logic                  wr_ok;
  logic                  rd_ok;

  // All status is decoded from the registered count, so flags move the edge after an access.
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign wr_ok = bus.winc && !full;
  assign rd_ok = bus.rinc && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr    <= rptr + AW'(1);
        rdata_q <= mem[rptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      if (bus.winc && full) begin
        overflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        overflow_q <= 1'b0;
      end
      if (bus.rinc && empty) begin
        underflow_q <= 1'b1;
      end else if (bus.clr_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  // In FWFT mode the head word is shown directly, and the last popped word is held while empty.
  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rdata = empty ? rdata_q : mem[rptr];
    end else begin : g_reg
      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.wfull         = full;
  assign bus.rempty        = empty;
  assign bus.walmost_full  = (count_q >= AF_CNT);
  assign bus.ralmost_empty = (count_q <= AE_CNT);
  assign bus.count         = count_q;
  assign bus.overflow      = overflow_q;
  assign bus.underflow     = underflow_q;
endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench for fifo_sync_flags: one registered-read instance and one FWFT instance.
module tb_fifo_sync_flags;
  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [7:0] exp_q [$];

  fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(8)) bus0 ();
  fifo_sync_flags_if #(.DATA_WIDTH(8), .DEPTH(8)) bus1 ();

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  fifo_sync_flags #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkers
  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // Drivers: inputs change 1 ns after a rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus0.winc  = 1'b1;
    bus0.wdata = d;
    tick();
    bus0.winc  = 1'b0;
    exp_q.push_back(d);
  endtask

  task automatic pop(input string tag);
    logic [7:0] e;
    bus0.rinc = 1'b1;
    tick();
    bus0.rinc = 1'b0;
    e = exp_q.pop_front();
    chk8(tag, bus0.rdata, e);
  endtask

  task automatic clear_err();
    bus0.clr_err = 1'b1;
    tick();
    bus0.clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    bus0.winc    = 1'b0;
    bus0.wdata   = 8'h00;
    bus0.rinc    = 1'b0;
    bus0.clr_err = 1'b0;
    bus1.winc    = 1'b0;
    bus1.wdata   = 8'h00;
    bus1.rinc    = 1'b0;
    bus1.clr_err = 1'b0;
    #12;
    rst = 1'b1;
    tick();

    // Reset asserted mid-clock while holding data.
    push(8'h5A);
    push(8'h3C);
    pop("pre_rst_rd");
    chk4("pre_rst_count", bus0.count, 4'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk1("rst_rempty", bus0.rempty, 1'b1);
    chk1("rst_wfull", bus0.wfull, 1'b0);
    chk4("rst_count", bus0.count, 4'd0);
    chk1("rst_ral_empty", bus0.ralmost_empty, 1'b1);
    chk1("rst_wal_full", bus0.walmost_full, 1'b0);
    chk8("rst_rdata", bus0.rdata, 8'h00);
    chk8("rst_rdata_fwft", bus1.rdata, 8'h00);
    chk1("rst_overflow", bus0.overflow, 1'b0);
    chk1("rst_underflow", bus0.underflow, 1'b0);
    exp_q.delete();
    #2;
    rst = 1'b1;
    tick();
    chk4("post_rst_count", bus0.count, 4'd0);

    // Fill 0x11..0x88 and watch flags.
    for (int i = 1; i <= 8; i++) begin
      push(8'(i * 17));
      chk4("fill_count", bus0.count, 4'(i));
      chk1("fill_ral_empty", bus0.ralmost_empty, i <= 2);
      chk1("fill_wal_full", bus0.walmost_full, i >= 6);
      chk1("fill_wfull", bus0.wfull, i == 8);
      chk1("fill_rempty", bus0.rempty, 1'b0);
    end
    bus0.winc  = 1'b1;
    bus0.wdata = 8'h99;
    tick();
    bus0.winc  = 1'b0;
    chk1("ovf_set", bus0.overflow, 1'b1);
    chk4("ovf_count", bus0.count, 4'd8);
    clear_err();
    chk1("ovf_clr", bus0.overflow, 1'b0);
    bus0.winc    = 1'b1;
    bus0.clr_err = 1'b1;
    tick();
    bus0.winc    = 1'b0;
    bus0.clr_err = 1'b0;
    chk1("ovf_set_wins", bus0.overflow, 1'b1);
    clear_err();
    chk1("ovf_clr2", bus0.overflow, 1'b0);

    // Registered read drain.
    for (int i = 0; i < 8; i++) begin
      pop("drain_rdata");
      chk4("drain_count", bus0.count, 4'(7 - i));
      chk1("drain_rempty", bus0.rempty, i == 7);
    end
    bus0.rinc = 1'b1;
    tick();
    bus0.rinc = 1'b0;
    chk1("udf_set", bus0.underflow, 1'b1);
    chk8("udf_rdata_hold", bus0.rdata, 8'h88);
    chk4("udf_count", bus0.count, 4'd0);
    clear_err();
    chk1("udf_clr", bus0.underflow, 1'b0);

    // Pointer wrap.
    for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 5; i++) pop("wrap5_rdata");
    for (int i = 0; i < 6; i++) push(8'(8'h40 + i));
    chk4("wrap_count6", bus0.count, 4'd6);
    for (int i = 0; i < 6; i++) pop("wrap6_rdata");
    chk4("wrap_count0", bus0.count, 4'd0);
    chk1("wrap_rempty", bus0.rempty, 1'b1);

    // Simultaneous read and write at count 3.
    push(8'h31);
    push(8'h32);
    push(8'h33);
    for (int k = 0; k < 4; k++) begin
      bus0.winc  = 1'b1;
      bus0.rinc  = 1'b1;
      bus0.wdata = 8'(8'h50 + k);
      tick();
      bus0.winc  = 1'b0;
      bus0.rinc  = 1'b0;
      e = exp_q.pop_front();
      chk8("rw_rdata", bus0.rdata, e);
      exp_q.push_back(8'(8'h50 + k));
      chk4("rw_count", bus0.count, 4'd3);
    end
    for (int k = 0; k < 5; k++) push(8'(8'h61 + k));
    chk1("rw_full", bus0.wfull, 1'b1);
    // Full with both strobes: the read wins and 0xEE is dropped.
    bus0.winc  = 1'b1;
    bus0.rinc  = 1'b1;
    bus0.wdata = 8'hEE;
    tick();
    bus0.winc  = 1'b0;
    bus0.rinc  = 1'b0;
    e = exp_q.pop_front();
    chk8("full_rw_rdata", bus0.rdata, e);
    chk4("full_rw_count", bus0.count, 4'd7);
    chk1("full_rw_ovf", bus0.overflow, 1'b1);
    for (int k = 0; k < 7; k++) pop("full_drain_rdata");
    chk4("full_drain_count", bus0.count, 4'd0);
    clear_err();
    // Empty with both strobes: the write wins.
    bus0.winc  = 1'b1;
    bus0.rinc  = 1'b1;
    bus0.wdata = 8'h77;
    tick();
    bus0.winc  = 1'b0;
    bus0.rinc  = 1'b0;
    exp_q.push_back(8'h77);
    chk4("empty_rw_count", bus0.count, 4'd1);
    chk1("empty_rw_udf", bus0.underflow, 1'b1);
    chk1("empty_rw_ovf", bus0.overflow, 1'b0);
    pop("empty_rw_rdata");
    chk4("empty_rw_end", bus0.count, 4'd0);

    // FWFT instance.
    chk1("fwft_init_rempty", bus1.rempty, 1'b1);
    chk8("fwft_init_rdata", bus1.rdata, 8'h00);
    bus1.winc  = 1'b1;
    bus1.wdata = 8'hA5;
    tick();
    bus1.winc  = 1'b0;
    chk1("fwft_rempty", bus1.rempty, 1'b0);
    chk8("fwft_rdata", bus1.rdata, 8'hA5);
    bus1.winc  = 1'b1;
    bus1.wdata = 8'hB6;
    tick();
    bus1.winc  = 1'b0;
    chk8("fwft_head_kept", bus1.rdata, 8'hA5);
    bus1.rinc = 1'b1;
    tick();
    bus1.rinc = 1'b0;
    chk8("fwft_next", bus1.rdata, 8'hB6);
    chk1("fwft_rempty2", bus1.rempty, 1'b0);
    bus1.rinc = 1'b1;
    tick();
    bus1.rinc = 1'b0;
    chk1("fwft_empty", bus1.rempty, 1'b1);
    chk8("fwft_hold", bus1.rdata, 8'hB6);
    chk1("fwft_udf", bus1.underflow, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
